// File: rtl/key_event_if.sv
// Key-event bundle: debounced key level in, registered event pulses and repeat count out.
interface key_event_if;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic [7:0] repeat_cnt;
    logic       key_busy;

    modport master (
        output key_level,
        input  press_pulse, release_pulse, click_pulse, long_pulse,
               repeat_pulse, repeat_cnt, key_busy
    );

    modport slave (
        input  key_level,
        output press_pulse, release_pulse, click_pulse, long_pulse,
               repeat_pulse, repeat_cnt, key_busy
    );
endinterface

// File: rtl/key_event.sv
// Turns a debounced active-low key level into one-clock press/release/click/
// long/repeat pulses plus a saturating repeat count; all outputs registered.
module key_event #(
    parameter int               CNT_W       = 26,
    parameter logic [CNT_W-1:0] LONG_TIME   = 26'd50_000_000,
    parameter logic [CNT_W-1:0] REPEAT_TIME = 26'd10_000_000
) (
    input  logic     clk,
    input  logic     nCR,
    key_event_if.slave kev
);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             key_level, key_d, press_edge;
    logic             press_q, release_q, click_q, long_q, repeat_q, busy_q;
    logic             press_nx, release_nx, click_nx, long_nx, repeat_nx, busy_nx;
    logic [7:0]       cnt_q, cnt_nx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign key_level  = kev.key_level;
    // key_d resets to 0, so a key already held at reset never forms an edge
    assign press_edge = key_d & ~key_level;

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            state     <= IDLE;
            timer     <= '0;
            key_d     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            key_d     <= key_level;
            press_q   <= press_nx;
            release_q <= release_nx;
            click_q   <= click_nx;
            long_q    <= long_nx;
            repeat_q  <= repeat_nx;
            busy_q    <= busy_nx;
            cnt_q     <= cnt_nx;
        end
    end

    // Release is tested first so it always beats a same-cycle timer expiry
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        case (state)
            IDLE: begin
                if (press_edge) begin
                    state_nx = HELD;
                    timer_nx = '0;
                end
            end
            HELD: begin
                if (key_level) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (timer == LONG_TIME - CNT_W'(1)) begin
                    state_nx = REPEAT;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (key_level) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (timer == REPEAT_TIME - CNT_W'(1)) begin
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_comb begin
        press_nx   = (state == IDLE) && press_edge;
        release_nx = (state != IDLE) && key_level;
        click_nx   = (state == HELD) && key_level;
        long_nx    = (state == HELD) && !key_level && (timer == LONG_TIME - CNT_W'(1));
        repeat_nx  = (state == REPEAT) && !key_level && (timer == REPEAT_TIME - CNT_W'(1));
        busy_nx    = (state_nx != IDLE);
        cnt_nx     = cnt_q;
        if (press_nx)
            cnt_nx = 8'd0;
        else if (repeat_nx)
            cnt_nx = sat_inc(cnt_q);
    end

    assign kev.press_pulse   = press_q;
    assign kev.release_pulse = release_q;
    assign kev.click_pulse   = click_q;
    assign kev.long_pulse    = long_q;
    assign kev.repeat_pulse  = repeat_q;
    assign kev.repeat_cnt    = cnt_q;
    assign kev.key_busy      = busy_q;
endmodule
